// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte producers.
// Optional done-wait watchdog is compiled in when UART_ARB_WDOG_EN is defined.
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int WDOG_CYCLES = 32,
  localparam int GW         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 clk_baud,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic [7:0]           tx_byte,
  output logic                 start_send,
  input  logic                 tx_done,
  output logic                 busy,
  output logic [GW-1:0]        grant_id,
  output logic                 wdog_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [GW-1:0]    r_ptr;
  logic [GW-1:0]    r_grant_id;
  logic [7:0]       r_tx_byte;
  logic [GW-1:0]    w_sel;
  logic [GW-1:0]    w_ptr_next;
  logic [7:0]       w_sel_data;
  logic             w_found;
  logic             w_grant;
  logic [N_REQ-1:0] w_onehot;
  logic [GW-1:0]    w_cand [N_REQ];

  generate
    if (N_REQ < 2 || N_REQ > 8 || WDOG_CYCLES < 2 || WDOG_CYCLES > 256) begin : g_bad_params
      $error("uart_tx_arbiter: N_REQ must be 2..8 and WDOG_CYCLES 2..256");
    end
  endgenerate

  // Candidate k is requester (ptr + k) mod N_REQ, so the search starts at ptr.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_cand
      logic [GW:0] w_sum;
      assign w_sum       = {1'b0, r_ptr} + (GW+1)'(gi);
      assign w_cand[gi]  = (w_sum >= (GW+1)'(N_REQ)) ? GW'(w_sum - (GW+1)'(N_REQ)) : GW'(w_sum);
    end
  endgenerate

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && req_valid[w_cand[k]]) begin
        w_found = 1'b1;
        w_sel   = w_cand[k];
      end
    end
  end

  assign w_ptr_next = (w_sel == GW'(N_REQ - 1)) ? '0 : w_sel + 1'b1;
  assign w_sel_data = req_data[8*int'(w_sel) +: 8];
  assign w_onehot   = {{(N_REQ-1){1'b0}}, 1'b1} << w_sel;

`ifdef UART_ARB_WDOG_EN
  logic [7:0] r_wcnt;
  logic       r_wdog_err;
  logic       w_timeout;

  // A done in the final watchdog cycle still completes the byte normally.
  assign w_timeout = (r_state == S_WAIT) && !tx_done && (r_wcnt == 8'(WDOG_CYCLES - 1));

  always_ff @(posedge clk_baud) begin
    if (rst) begin
      r_wcnt     <= '0;
      r_wdog_err <= 1'b0;
    end else begin
      r_wdog_err <= w_timeout;
      if (r_state != S_WAIT) r_wcnt <= '0;
      else                   r_wcnt <= r_wcnt + 8'd1;
    end
  end

  assign wdog_err = r_wdog_err;
`else
  assign wdog_err = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_next = S_START;
          w_grant      = 1'b1;
        end
      end
      S_START: w_state_next = S_WAIT;
      S_WAIT: begin
        if (tx_done) w_state_next = S_IDLE;
`ifdef UART_ARB_WDOG_EN
        else if (w_timeout) w_state_next = S_IDLE;
`endif
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_baud) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_tx_byte  <= '0;
      r_grant_id <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant) begin
        r_tx_byte  <= w_sel_data;
        r_grant_id <= w_sel;
        r_ptr      <= w_ptr_next;
      end
    end
  end

  // Accept is masked during reset so no producer believes its byte was taken.
  assign req_ready  = (r_state == S_IDLE && w_found && !rst) ? w_onehot : '0;
  assign start_send = (r_state == S_START);
  assign busy       = (r_state != S_IDLE);
  assign tx_byte    = r_tx_byte;
  assign grant_id   = r_grant_id;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: timestamp-based reference model plus a UART model
// that answers start_send with a done pulse 11 cycles later.
module tb_uart_tx_arbiter;
  localparam int N        = 4;
  localparam int WDOG     = 32;
  localparam int UART_LAT = 11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic [7:0]  tx_byte;
  logic        start_send;
  logic        tx_done = 1'b0;
  logic        busy;
  logic [1:0]  grant_id;
  logic        wdog_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit uart_on = 1'b1;
  int ucnt  = 0;

  // Reference model: an accept at cycle A means start at A+1 and idle again at
  // A+13 (UART done at A+12), or at A+2+WDOG when the watchdog has to fire.
  int         m_ptr  = 0;
  int         m_free = 0;
  int         m_acc  = -100;
  int         m_wdog = -100;
  logic [7:0] m_byte = '0;
  int         m_gid  = 0;
  logic [3:0] exp_ready;
  logic       exp_start;
  logic       exp_busy;
  logic       exp_wdog;
  int         exp_sel;

  uart_tx_arbiter #(.N_REQ(N), .WDOG_CYCLES(WDOG)) dut (
    .clk_baud   (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .tx_byte    (tx_byte),
    .start_send (start_send),
    .tx_done    (tx_done),
    .busy       (busy),
    .grant_id   (grant_id),
    .wdog_err   (wdog_err)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(negedge clk);
    if (uart_on && start_send === 1'b1) begin
      ucnt    = UART_LAT;
      tx_done = 1'b0;
    end else if (ucnt > 0) begin
      ucnt--;
      tx_done = (ucnt == 0);
    end else begin
      tx_done = 1'b0;
    end
  end

  task automatic model_eval();
    exp_busy  = (cyc < m_free);
    exp_start = (cyc == m_acc + 1);
    exp_wdog  = (cyc == m_wdog);
    exp_ready = '0;
    exp_sel   = -1;
    if (!rst && !exp_busy) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (exp_sel < 0 && req_valid[j]) exp_sel = j;
      end
    end
    if (exp_sel >= 0) exp_ready = 4'b0001 << exp_sel;
  endtask

  task automatic model_commit();
    if (rst) begin
      m_ptr = 0; m_free = cyc + 1; m_acc = -100; m_wdog = -100; m_byte = '0; m_gid = 0;
    end else if (exp_sel >= 0) begin
      m_acc  = cyc;
      m_byte = req_data[8*exp_sel +: 8];
      m_gid  = exp_sel;
      m_ptr  = (exp_sel + 1) % N;
      if (uart_on) begin
        m_free = cyc + 2 + UART_LAT;
      end else begin
        m_free = cyc + 2 + WDOG;
        m_wdog = m_free;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst = 1'b1; req_valid = 4'hF; req_data = $urandom;
      #1; model_eval();
      total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL reset_ready cyc=%0d got=%b want=0000", cyc, req_ready); end
      total++; if (start_send !== 1'b0) begin bad++; $display("FAIL reset_start cyc=%0d got=%b want=0", cyc, start_send); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy cyc=%0d got=%b want=0", cyc, busy); end
      total++; if (tx_byte !== 8'h00) begin bad++; $display("FAIL reset_txbyte cyc=%0d got=%h want=00", cyc, tx_byte); end
      total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant cyc=%0d got=%0d want=0", cyc, grant_id); end
      total++; if (wdog_err !== 1'b0) begin bad++; $display("FAIL reset_wdog cyc=%0d got=%b want=0", cyc, wdog_err); end
      model_commit();
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] seen[$];
    int last_start = -1000;
    for (int i = 0; i < 78; i++) begin
      @(negedge clk);
      rst = 1'b0; req_data = 32'h13121110;
      req_valid = (i < 60) ? 4'hF : 4'h0;
      #1; model_eval();
      total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL rr_ready cyc=%0d got=%b want=%b", cyc, req_ready, exp_ready); end
      total++; if (start_send !== exp_start) begin bad++; $display("FAIL rr_start cyc=%0d got=%b want=%b", cyc, start_send, exp_start); end
      total++; if (busy !== exp_busy) begin bad++; $display("FAIL rr_busy cyc=%0d got=%b want=%b", cyc, busy, exp_busy); end
      if (start_send === 1'b1) begin
        seen.push_back(tx_byte);
        total++; if (cyc - last_start < 13) begin bad++; $display("FAIL rr_spacing cyc=%0d got=%0d want>=13", cyc, cyc - last_start); end
        last_start = cyc;
      end
      model_commit();
    end
    total++; if (seen.size() != 5) begin bad++; $display("FAIL rr_count got=%0d want=5", seen.size()); end
    for (int k = 0; k < 5 && k < seen.size(); k++) begin
      total++; if (seen[k] !== 8'(8'h10 + k % 4)) begin bad++; $display("FAIL rr_order idx=%0d got=%h want=%h", k, seen[k], 8'h10 + k % 4); end
    end
  endtask

  task automatic test_single();
    req_data = {8'($urandom), 8'hA5, 8'($urandom), 8'($urandom)};
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      req_valid = (i == 0) ? 4'b0100 : 4'b0000;
      #1; model_eval();
      if (i == 0) begin
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready got=%b want=0100", req_ready); end
      end
      if (i == 1) begin
        total++; if (start_send !== 1'b1) begin bad++; $display("FAIL single_start got=%b want=1", start_send); end
        total++; if (tx_byte !== 8'hA5) begin bad++; $display("FAIL single_txbyte got=%h want=a5", tx_byte); end
        total++; if (grant_id !== 2'd2) begin bad++; $display("FAIL single_grant got=%0d want=2", grant_id); end
      end
      total++; if (start_send !== exp_start) begin bad++; $display("FAIL single_pulse cyc=%0d got=%b want=%b", cyc, start_send, exp_start); end
      total++; if (busy !== exp_busy) begin bad++; $display("FAIL single_busy i=%0d got=%b want=%b", i, busy, exp_busy); end
      model_commit();
    end
  endtask

  task automatic test_withdraw();
    logic       pend0 = 1'b0;
    logic       pend3 = 1'b0;
    logic [7:0] seen[$];
    req_data = 32'h23222120;
    for (int i = 0; i < 42; i++) begin
      @(negedge clk);
      if (i == 0) pend3 = 1'b1;
      if (i == 2) begin pend0 = 1'b1; pend3 = 1'b1; end
      req_valid = {pend3, 1'b0, (i >= 3 && i <= 7), pend0};
      #1; model_eval();
      if (i == 0) begin
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL wd_first got=%b want=1000", req_ready); end
      end
      if (i == 13) begin
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL wd_wrap got=%b want=0001", req_ready); end
      end
      total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL wd_ready cyc=%0d got=%b want=%b", cyc, req_ready, exp_ready); end
      total++; if (start_send !== exp_start) begin bad++; $display("FAIL wd_start cyc=%0d got=%b want=%b", cyc, start_send, exp_start); end
      if (start_send === 1'b1) begin
        seen.push_back(tx_byte);
        total++; if (tx_byte === 8'h21) begin bad++; $display("FAIL wd_withdrawn_sent cyc=%0d got=%h want!=21", cyc, tx_byte); end
      end
      model_commit();
      pend0 = pend0 & ~exp_ready[0];
      pend3 = pend3 & ~exp_ready[3];
    end
    total++; if (seen.size() != 3) begin bad++; $display("FAIL wd_count got=%0d want=3", seen.size()); end
    if (seen.size() == 3) begin
      total++; if ({seen[0], seen[1], seen[2]} !== 24'h232023) begin bad++; $display("FAIL wd_order got=%h%h%h want=232023", seen[0], seen[1], seen[2]); end
    end
  endtask

  task automatic test_random();
    logic [3:0] pend = '0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && i < 380 && $urandom_range(3) == 0) begin
          pend[k] = 1'b1;
          req_data[8*k +: 8] = 8'($urandom);
        end else if (pend[k] && $urandom_range(31) == 0) begin
          pend[k] = 1'b0;
        end
      end
      if (i >= 380) pend = '0;
      req_valid = pend;
      #1; model_eval();
      total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", cyc, req_ready, exp_ready); end
      total++; if (start_send !== exp_start) begin bad++; $display("FAIL rnd_start cyc=%0d got=%b want=%b", cyc, start_send, exp_start); end
      total++; if (busy !== exp_busy) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%b want=%b", cyc, busy, exp_busy); end
      total++; if (tx_byte !== m_byte) begin bad++; $display("FAIL rnd_txbyte cyc=%0d got=%h want=%h", cyc, tx_byte, m_byte); end
      total++; if (grant_id !== 2'(m_gid)) begin bad++; $display("FAIL rnd_grant cyc=%0d got=%0d want=%0d", cyc, grant_id, m_gid); end
      total++; if (wdog_err !== exp_wdog) begin bad++; $display("FAIL rnd_wdog cyc=%0d got=%b want=%b", cyc, wdog_err, exp_wdog); end
      model_commit();
      pend = pend & ~exp_ready;
    end
  endtask

  task automatic test_reset_mid_wait();
    req_data = $urandom;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      rst = (i == 5);
      req_valid = (i == 0) ? 4'b0010 : (i == 15) ? 4'b1111 : 4'b0000;
      #1; model_eval();
      if (i == 6) begin
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_wait_busy got=%b want=0", busy); end
      end
      if (i == 15) begin
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rst_wait_ptr got=%b want=0001", req_ready); end
      end
      total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL rst_wait_ready cyc=%0d got=%b want=%b", cyc, req_ready, exp_ready); end
      total++; if (start_send !== exp_start) begin bad++; $display("FAIL rst_wait_start cyc=%0d got=%b want=%b", cyc, start_send, exp_start); end
      total++; if (busy !== exp_busy) begin bad++; $display("FAIL rst_wait_busy_seq cyc=%0d got=%b want=%b", cyc, busy, exp_busy); end
      total++; if (tx_byte !== m_byte) begin bad++; $display("FAIL rst_wait_txbyte cyc=%0d got=%h want=%h", cyc, tx_byte, m_byte); end
      model_commit();
    end
    rst = 1'b0;
  endtask

`ifdef UART_ARB_WDOG_EN
  task automatic test_wdog();
    logic pend0 = 1'b0;
    uart_on  = 1'b0;
    req_data = $urandom;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (i == 5) pend0 = 1'b1;
      req_valid = {1'b0, (i == 0), 1'b0, pend0};
      #1; model_eval();
      if (i == 34) begin
        total++; if (wdog_err !== 1'b1) begin bad++; $display("FAIL wdog_pulse got=%b want=1", wdog_err); end
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL wdog_next_grant got=%b want=0001", req_ready); end
      end
      total++; if (wdog_err !== exp_wdog) begin bad++; $display("FAIL wdog_seq cyc=%0d got=%b want=%b", cyc, wdog_err, exp_wdog); end
      total++; if (busy !== exp_busy) begin bad++; $display("FAIL wdog_busy cyc=%0d got=%b want=%b", cyc, busy, exp_busy); end
      total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL wdog_ready cyc=%0d got=%b want=%b", cyc, req_ready, exp_ready); end
      model_commit();
      pend0 = pend0 & ~exp_ready[0];
    end
    uart_on = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_withdraw();
    test_random();
    test_reset_mid_wait();
`ifdef UART_ARB_WDOG_EN
    test_wdog();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
